// File: rtl/clk_cal_pkg.sv
// Shared BCD helpers for the clock/calendar counters.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package clk_cal_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX_DIGIT = 4'd9;

    function automatic logic bcd_is_legal(input bcd_t h, input bcd_t l);
        return (h <= BCD_MAX_DIGIT) && (l <= BCD_MAX_DIGIT);
    endfunction

    // Eight bits so non-BCD digits (up to 15*10+15) cannot alias into range.
    function automatic logic [7:0] bcd_to_bin(input bcd_t h, input bcd_t l);
        return ({4'd0, h} * 8'd10) + {4'd0, l};
    endfunction

    function automatic logic [7:0] bin_to_bcd(input int n);
        bcd_t h;
        bcd_t l;
        h = 4'(n / 10);
        l = 4'(n % 10);
        return {h, l};
    endfunction

    function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/bcd2_incdec.sv
// Two-digit BCD increment/decrement; wrap at the field bounds is decided by the parent.
// Latency: combinational.
// Backpressure: none.
module bcd2_incdec
    import clk_cal_pkg::*;
(
    input  bcd_t h,
    input  bcd_t l,
    input  logic dir,
    output bcd_t hNext,
    output bcd_t lNext
);

    always_comb begin
        hNext = h;
        lNext = l;
        if (dir) begin
            if (l >= BCD_MAX_DIGIT) begin
                lNext = 4'd0;
                hNext = h + 4'd1;
            end else begin
                lNext = l + 4'd1;
            end
        end else begin
            if (l == 4'd0) begin
                lNext = BCD_MAX_DIGIT;
                hNext = h - 4'd1;
            end else begin
                lNext = l - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down modulo counter with load, wrap carry and illegal-state flag.
// Latency: count, CO and Err all register on the same CP edge.
// Backpressure: none; EN low holds the count and chains CO into the next field.
module bcd_mod_counter
    import clk_cal_pkg::*;
#(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 23,
    parameter int DYN_MAX = 0
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       EN,
    input  logic       Dir,
    input  logic       nLD,
    input  logic [3:0] DinH,
    input  logic [3:0] DinL,
    input  logic [3:0] MaxH,
    input  logic [3:0] MaxL,
    output logic [3:0] CntH,
    output logic [3:0] CntL,
    output logic       CO,
    output logic       Err
);

    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= 99)) begin : gBadParams
        $fatal(1, "bcd_mod_counter: need 0 <= MIN_VAL < MAX_VAL <= 99");
    end

    localparam logic [7:0] MIN_BIN = 8'(MIN_VAL);
    localparam logic [7:0] MAX_BIN = 8'(MAX_VAL);
    localparam logic [7:0] MIN_BCD = bin_to_bcd(MIN_VAL);
    localparam logic [7:0] MAX_BCD = bin_to_bcd(MAX_VAL);

    logic [7:0] curBin;
    logic [7:0] dinBin;
    logic [7:0] maxBin;
    logic [7:0] effMaxBin;
    logic [7:0] effMaxBcd;
    logic       dynOk;
    logic       curLegal;
    logic       dinLegal;
    bcd_t       stepH;
    bcd_t       stepL;

    assign curBin = bcd_to_bin(CntH, CntL);
    assign dinBin = bcd_to_bin(DinH, DinL);
    assign maxBin = bcd_to_bin(MaxH, MaxL);

    // A runtime bound that is non-BCD or not above MIN_VAL falls back to MAX_VAL.
    assign dynOk     = (DYN_MAX != 0) && bcd_is_legal(MaxH, MaxL) && (maxBin > MIN_BIN);
    assign effMaxBin = dynOk ? maxBin : MAX_BIN;
    assign effMaxBcd = dynOk ? {MaxH, MaxL} : MAX_BCD;

    assign curLegal = bcd_is_legal(CntH, CntL) && bcd_in_range(curBin, MIN_BIN, effMaxBin);
    assign dinLegal = bcd_is_legal(DinH, DinL) && bcd_in_range(dinBin, MIN_BIN, effMaxBin);

    bcd2_incdec uIncDec (
        .h     (CntH),
        .l     (CntL),
        .dir   (Dir),
        .hNext (stepH),
        .lNext (stepL)
    );

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            {CntH, CntL} <= MIN_BCD;
            CO           <= 1'b0;
            Err          <= 1'b0;
        end else begin
            CO  <= 1'b0;
            Err <= 1'b0;
            if (EN) begin
                if (!nLD) begin
                    if (dinLegal) begin
                        {CntH, CntL} <= {DinH, DinL};
                    end else begin
                        {CntH, CntL} <= MIN_BCD;
                        Err          <= 1'b1;
                    end
                end else if (!curLegal) begin
                    {CntH, CntL} <= MIN_BCD;
                    Err          <= 1'b1;
                end else if (Dir && (curBin == effMaxBin)) begin
                    {CntH, CntL} <= MIN_BCD;
                    CO           <= 1'b1;
                end else if (!Dir && (curBin == MIN_BIN)) begin
                    {CntH, CntL} <= effMaxBcd;
                    CO           <= 1'b1;
                end else begin
                    {CntH, CntL} <= {stepH, stepL};
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed scoreboard bench for bcd_mod_counter across three field configurations.
// Stimulus pushes expected outputs; a monitor pops and compares after each CP edge.
module tb_bcd_mod_counter;

    logic       CP = 1'b0;
    logic       nCR = 1'b0;
    logic       EN = 1'b0;
    logic       Dir = 1'b1;
    logic       nLD = 1'b1;
    logic [3:0] DinH = 4'd0;
    logic [3:0] DinL = 4'd0;
    logic [3:0] MaxH = 4'd0;
    logic [3:0] MaxL = 4'd0;

    logic [3:0] h0, l0, h1, l1, h2, l2;
    logic       co0, co1, co2, err0, err1, err2;

    always #5 CP = ~CP;

    bcd_mod_counter u0 (
        .CP(CP), .nCR(nCR), .EN(EN), .Dir(Dir), .nLD(nLD), .DinH(DinH), .DinL(DinL),
        .MaxH(MaxH), .MaxL(MaxL), .CntH(h0), .CntL(l0), .CO(co0), .Err(err0)
    );

    bcd_mod_counter #(.MIN_VAL(1), .MAX_VAL(12), .DYN_MAX(0)) u1 (
        .CP(CP), .nCR(nCR), .EN(EN), .Dir(Dir), .nLD(nLD), .DinH(DinH), .DinL(DinL),
        .MaxH(MaxH), .MaxL(MaxL), .CntH(h1), .CntL(l1), .CO(co1), .Err(err1)
    );

    bcd_mod_counter #(.MIN_VAL(1), .MAX_VAL(31), .DYN_MAX(1)) u2 (
        .CP(CP), .nCR(nCR), .EN(EN), .Dir(Dir), .nLD(nLD), .DinH(DinH), .DinL(DinL),
        .MaxH(MaxH), .MaxL(MaxL), .CntH(h2), .CntL(l2), .CO(co2), .Err(err2)
    );

    typedef struct {
        int         dut;
        logic [7:0] cnt;
        logic       co;
        logic       err;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];
    int    tests = 0;
    int    fails = 0;
    int    sel = 0;

    function automatic logic [9:0] dutOut(input int d);
        case (d)
            0:       return {h0, l0, co0, err0};
            1:       return {h1, l1, co1, err1};
            default: return {h2, l2, co2, err2};
        endcase
    endfunction

    function automatic logic [7:0] toBcd(input int v);
        logic [3:0] th;
        logic [3:0] tl;
        th = 4'(v / 10);
        tl = 4'(v % 10);
        return {th, tl};
    endfunction

    task automatic compare(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got cnt=%h co=%b err=%b, expected cnt=%h co=%b err=%b",
                     name, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
        end
    endtask

    // Monitor: the counter presents a result after every edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge CP);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                compare(n, dutOut(e.dut), {e.cnt, e.co, e.err});
            end
        end
    end

    task automatic step(input logic en, input logic dir, input logic nld,
                        input logic [7:0] din, input logic [7:0] maxv,
                        input logic [7:0] cnt, input logic co, input logic err,
                        input string name);
        exp_t e;
        @(negedge CP);
        EN  = en;
        Dir = dir;
        nLD = nld;
        {DinH, DinL} = din;
        {MaxH, MaxL} = maxv;
        e.dut = sel;
        e.cnt = cnt;
        e.co  = co;
        e.err = err;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic doReset(input int d, input logic [7:0] rv, input string name);
        @(negedge CP);
        EN  = 1'b0;
        nLD = 1'b1;
        Dir = 1'b1;
        nCR = 1'b0;
        sel = d;
        #2;
        compare(name, dutOut(d), {rv, 2'b00});
        #1;
        nCR = 1'b1;
    endtask

    // Reset asserted between edges must clear outputs without waiting for CP.
    task automatic midReset(input logic [7:0] rv, input string name);
        @(posedge CP);
        #3;
        nCR = 1'b0;
        #1;
        compare(name, dutOut(sel), {rv, 2'b00});
        @(negedge CP);
        nCR = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Defaults 0..23
        doReset(0, 8'h00, "rst_default");
        for (int k = 1; k <= 25; k++)
            step(1, 1, 1, 8'h00, 8'h00, toBcd(k % 24), (k == 24), 1'b0, $sformatf("up%0d", k));
        step(1, 1, 0, 8'h19, 8'h00, 8'h19, 0, 0, "ld19");
        step(1, 1, 0, 8'h3A, 8'h00, 8'h00, 0, 1, "ld3A_nonbcd");
        step(1, 1, 1, 8'h00, 8'h00, 8'h01, 0, 0, "err_one_cycle");
        step(1, 1, 0, 8'h25, 8'h00, 8'h00, 0, 1, "ld25_over_max");
        step(1, 1, 0, 8'h23, 8'h00, 8'h23, 0, 0, "ld23_at_max");
        for (int i = 0; i < 5; i++)
            step(0, 1, (i == 2) ? 1'b0 : 1'b1, 8'h05, 8'h00, 8'h23, 0, 0,
                 $sformatf("hold%0d", i));
        step(1, 1, 1, 8'h00, 8'h00, 8'h00, 1, 0, "wrap_after_hold");
        step(1, 0, 1, 8'h00, 8'h00, 8'h23, 1, 0, "dn_wrap_00");
        step(1, 0, 1, 8'h00, 8'h00, 8'h22, 0, 0, "dn_22");
        step(1, 1, 0, 8'h15, 8'h00, 8'h15, 0, 0, "ld15");
        midReset(8'h00, "arst_at_15");
        step(1, 1, 0, 8'h99, 8'h00, 8'h00, 0, 1, "ld99");
        midReset(8'h00, "arst_clears_err");
        step(1, 1, 0, 8'h23, 8'h00, 8'h23, 0, 0, "ld23_again");
        step(1, 1, 1, 8'h00, 8'h00, 8'h00, 1, 0, "wrap_co");
        midReset(8'h00, "arst_clears_co");

        // 1..12 hours field
        doReset(1, 8'h01, "rst_hours12");
        step(1, 0, 1, 8'h00, 8'h00, 8'h12, 1, 0, "h12_dn_wrap");
        step(1, 0, 1, 8'h00, 8'h00, 8'h11, 0, 0, "h12_dn_11");
        step(1, 1, 0, 8'h09, 8'h00, 8'h09, 0, 0, "h12_ld09");
        step(1, 1, 1, 8'h00, 8'h00, 8'h10, 0, 0, "h12_bcd_carry");
        step(1, 0, 1, 8'h00, 8'h00, 8'h09, 0, 0, "h12_bcd_borrow");
        step(1, 1, 0, 8'h12, 8'h00, 8'h12, 0, 0, "h12_ld12");
        step(1, 1, 1, 8'h00, 8'h00, 8'h01, 1, 0, "h12_up_wrap");
        step(1, 1, 0, 8'h00, 8'h00, 8'h01, 0, 1, "h12_ld00_below_min");
        step(1, 1, 0, 8'h13, 8'h00, 8'h01, 0, 1, "h12_ld13_over_max");

        // Days field, runtime bound
        doReset(2, 8'h01, "rst_days");
        step(1, 1, 0, 8'h27, 8'h28, 8'h27, 0, 0, "day_ld27");
        step(1, 1, 1, 8'h00, 8'h28, 8'h28, 0, 0, "day_up28");
        step(1, 1, 1, 8'h00, 8'h28, 8'h01, 1, 0, "day_wrap28");
        step(1, 0, 1, 8'h00, 8'h28, 8'h28, 1, 0, "day_dn_wrap28");
        step(1, 1, 0, 8'h30, 8'h31, 8'h30, 0, 0, "day_ld30");
        step(1, 1, 1, 8'h00, 8'h28, 8'h01, 0, 1, "day_max_drop");
        step(1, 1, 1, 8'h00, 8'h28, 8'h02, 0, 0, "day_after_drop");
        step(1, 1, 0, 8'h30, 8'h0F, 8'h30, 0, 0, "day_ld30_fallback");
        step(1, 1, 1, 8'h00, 8'h0F, 8'h31, 0, 0, "day_up31_fallback");
        step(1, 1, 1, 8'h00, 8'h0F, 8'h01, 1, 0, "day_wrap_fallback");
        step(1, 0, 1, 8'h00, 8'h01, 8'h31, 1, 0, "day_dn_max_le_min");
        step(1, 1, 0, 8'h29, 8'h28, 8'h01, 0, 1, "day_ld29_over_max");

        repeat (3) @(negedge CP);
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Parametrised two-digit 8421-BCD modulo counter for the clock/calendar datapath. It covers hours (0-23 or 1-12), minutes/seconds (0-59), months (1-12) and days (1-28/29/30/31 via a runtime upper bound). It adds up/down counting, synchronous load, a registered wrap/borrow carry-out and illegal-state flagging. It instantiates once per time field and chains via CO into the next field's EN.

Parameters:
MIN_VAL, 0, lowest count value (decimal, 0..98); wrap target when counting up.
MAX_VAL, 23, highest count value (decimal, MIN_VAL+1..99); static upper bound and fallback bound.
DYN_MAX, 0, 1 = upper bound taken from MaxH:MaxL at runtime; 0 = MaxH/MaxL ignored.

Ports:
CP  input  1  count clock, rising edge
nCR  input  1  asynchronous active-low clear
EN  input  1  count enable; low = hold
Dir  input  1  1 = count up, 0 = count down
nLD  input  1  synchronous active-low parallel load
DinH  input  4  load value, tens digit (BCD)
DinL  input  4  load value, units digit (BCD)
MaxH  input  4  runtime upper bound, tens digit (used only when DYN_MAX=1)
MaxL  input  4  runtime upper bound, units digit
CntH  output  4  count, tens digit (BCD)
CntL  output  4  count, units digit (BCD)
CO  output  1  registered one-cycle wrap/borrow pulse
Err  output  1  registered one-cycle illegal-state/illegal-load pulse

Behaviour:
- One clock CP. Reset nCR is asynchronous and active-low. On reset: {CntH,CntL}=BCD(MIN_VAL), CO=0, Err=0.
- Elaboration check: 0<=MIN_VAL<MAX_VAL<=99; otherwise fatal.
- effMAX:
  - DYN_MAX=0: MAX_VAL.
  - DYN_MAX=1: MaxH:MaxL. Fall back to MAX_VAL if either digit >9, or the value <=MIN_VAL.
- "legal(v)": both digits <=9 and MIN_VAL<=v<=effMAX.
- Priority on each rising CP edge, highest first:
  1. EN=0: hold count; CO=0; Err=0.
  2. nLD=0: if legal(Din), load Din with Err=0; else load MIN_VAL with Err=1. CO=0.
  3. Current value illegal (non-BCD digit, or outside [MIN_VAL,effMAX], including effMAX dropping below the count): next=MIN_VAL, Err=1, CO=0.
  4. Dir=1 and value==effMAX: next=MIN_VAL, CO=1.
  5. Dir=1 otherwise: BCD +1 (units 9 -> 0 with tens +1), CO=0.
  6. Dir=0 and value==MIN_VAL: next=effMAX, CO=1.
  7. Dir=0 otherwise: BCD -1 (units 0 -> 9 with tens -1), CO=0.
- Err=0 in all non-error cases.
- CO and Err are registered. Each is high for exactly the one cycle following the edge that caused it, and deasserts on the next edge unless re-triggered.
- Latency: count, CO and Err all update on the same edge; no combinational path from inputs to outputs.
- Dir may change any cycle; it takes effect on the next edge.
- MaxH/MaxL may change any cycle. A reduction below the current count is handled by rule 3 on the next enabled edge.
- nCR asserted mid-cycle forces the reset values immediately, independent of CP.

Decomposition:
- Shared package clk_cal_pkg:
  - BCD digit type (4-bit).
  - Constant BCD_MAX_DIGIT=9.
  - Functions bcd_is_legal(h,l), bcd_to_bin(h,l), bin_to_bcd(n) for parameter-to-BCD conversion of MIN_VAL/MAX_VAL.
- One combinational sub-module, bcd2_incdec: two-digit BCD +/-1.
  - Inputs: h, l, dir.
  - Outputs: next h, next l.
  - Wrap selection stays in the parent.

Test Plan:
- Defaults (0..23), EN=1, Dir=1, nLD=1, 25 edges from reset -> 00,01..09,10..19,20..23,00,01; CO high only in the cycle after 23->00.
- MIN_VAL=1, MAX_VAL=12, Dir=0 from reset -> 01 then 12 with CO=1, then 11; Dir=1 from 09 -> 10 (BCD carry); Dir=0 from 10 -> 09 (BCD borrow).
- Defaults, nLD=0 with Din=0x19 -> 19, Err=0, CO=0. nLD=0 with Din=0x3A -> 00, Err=1 for one cycle. nLD=0 with Din=0x25 -> 00, Err=1.
- DYN_MAX=1, MIN_VAL=1, MAX_VAL=31:
  - Max=0x28: 27,28,01 with CO on wrap.
  - Load 0x30 with Max=0x31, then set Max=0x28 -> next edge 01, Err=1.
  - Max=0x0F (illegal) -> counts to 31 (fallback).
- EN=0 for 5 edges at 0x23 -> holds 23, CO=0; EN=1 -> 00 with CO=1.
- Assert nCR between edges at count 0x15 -> outputs 00 immediately; CO and Err cleared.
